// File: rtl/mpi_bus_sender.sv
// mpi_bus_sender: buffers one flit packet, polls endpoint send space, then writes length and flits over the generic bus
module mpi_bus_sender #(
  parameter int          NOC_FLIT_WIDTH = 32,
  parameter int          SIZE           = 16,
  parameter int          ENDPOINT       = 0,
  parameter logic [31:0] BASE_ADDR      = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NOC_FLIT_WIDTH-1:0] in_flit,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [31:0]               bus_addr,
  output logic                      bus_we,
  output logic                      bus_en,
  output logic [31:0]               bus_data_out,
  input  logic [31:0]               bus_data_in,
  input  logic                      bus_ack,
  input  logic                      bus_err,
  output logic                      busy,
  output logic                      pkt_done,
  output logic                      err
);
  localparam int          IW          = $clog2(SIZE);
  localparam int          CW          = IW + 1;
  localparam logic [31:0] DATA_ADDR   = BASE_ADDR | (32'(ENDPOINT + 1) << 13);
  localparam logic [31:0] STATUS_ADDR = DATA_ADDR + 32'h4;
  typedef enum logic [2:0] {IDLE, COLLECT, POLL, WRLEN, WRFLIT, DONE, ERROR} state_t;
  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [IW-1:0]             r_idx;
  logic                      r_ovf;
  logic                      r_bus_en;
  logic                      r_we;
  logic [31:0]               r_addr;
  logic [31:0]               r_wdata;
  logic                      r_pkt_done;
  logic                      r_err;
  logic [NOC_FLIT_WIDTH-1:0] r_mem [SIZE];
  logic                      w_collect;
  logic                      w_full;
  assign w_collect    = (r_state == IDLE) || (r_state == COLLECT);
  assign w_full       = r_cnt == CW'(SIZE);
  assign in_ready     = w_collect;
  assign busy         = !w_collect;
  assign bus_en       = r_bus_en;
  assign bus_we       = r_we;
  assign bus_addr     = r_addr;
  assign bus_data_out = r_wdata;
  assign pkt_done     = r_pkt_done;
  assign err          = r_err;
  always_ff @(posedge clk)
    if (w_collect && in_valid && !w_full) r_mem[r_cnt[IW-1:0]] <= in_flit;
  // Every bus state: enter with bus_en low, raise it next cycle, hold until ack/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_ovf      <= 1'b0;
      r_bus_en   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_pkt_done <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        IDLE, COLLECT: if (in_valid) begin
          if (r_state == IDLE) r_err <= 1'b0;
          if (w_full) begin
            r_ovf <= 1'b1;
            r_err <= 1'b1;
          end else r_cnt <= r_cnt + CW'(1);
          if (!in_last) r_state <= COLLECT;
          else if (r_ovf || w_full) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end else begin
            r_state <= POLL;
            r_addr  <= STATUS_ADDR;
            r_we    <= 1'b0;
          end
        end
        POLL, WRLEN, WRFLIT: if (!r_bus_en) r_bus_en <= 1'b1;
        else if (bus_err) begin
          r_bus_en <= 1'b0;
          r_err    <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ERROR;
        end else if (bus_ack) begin
          r_bus_en <= 1'b0;
          if (r_state == POLL) begin
            if (bus_data_in > 32'(r_cnt)) begin
              r_state <= WRLEN;
              r_addr  <= DATA_ADDR;
              r_we    <= 1'b1;
              r_wdata <= 32'(r_cnt);
            end
          end else if (r_state == WRLEN) begin
            r_state <= WRFLIT;
            r_idx   <= '0;
            r_wdata <= 32'(r_mem[0]);
          end else if ({1'b0, r_idx} == r_cnt - CW'(1)) begin
            r_state    <= DONE;
            r_pkt_done <= 1'b1;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_wdata <= 32'(r_mem[r_idx + IW'(1)]);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpi_bus_sender.sv
// tb_mpi_bus_sender: scoreboard bench; a bus slave model answers accesses, a monitor pops expected accesses
module tb_mpi_bus_sender;
  localparam int          SIZE   = 16;
  localparam logic [31:0] DATA   = 32'h2000;
  localparam logic [31:0] STATUS = 32'h2004;
  logic        clk = 0, rst = 1;
  logic [31:0] in_flit = 0;
  logic        in_last = 0, in_valid = 0;
  logic        in_ready, bus_we, bus_en, busy, pkt_done, err;
  logic [31:0] bus_addr, bus_data_out;
  logic [31:0] bus_data_in = 0;
  logic        bus_ack = 0, bus_err = 0;
  mpi_bus_sender #(.NOC_FLIT_WIDTH(32), .SIZE(SIZE), .ENDPOINT(0), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .bus_ack(bus_ack),
    .bus_err(bus_err), .busy(busy), .pkt_done(pkt_done), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} acc_t;
  acc_t        exp_q[$];
  acc_t        e_m;
  logic [31:0] status_q[$];
  int checks = 0, errors = 0;
  int ack_delay = 0, err_at = -1, wr_n = 0, acc_n = 0, done_n = 0, wait_n = 0;
  bit stall = 0, no_bus = 0;
  logic        p_en = 0, p_fin = 0, p_we = 0;
  logic [31:0] p_addr = 0, p_data = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void push(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{we, a, d});
  endfunction
  // Slave: responds ack_delay (+ random stall) cycles after bus_en rises; reads pop status_q.
  initial forever begin
    @(posedge clk); #1;
    bus_ack = 0;
    bus_err = 0;
    if (!bus_en) wait_n = ack_delay + (stall ? int'($urandom_range(0, 3)) : 0);
    else if (wait_n > 0) wait_n--;
    else begin
      if (bus_we) wr_n++;
      if (bus_we && wr_n == err_at) bus_err = 1;
      else begin
        bus_ack = 1;
        if (!bus_we) bus_data_in = status_q.size() > 0 ? status_q.pop_front() : 32'd16;
      end
    end
  end
  // Monitor: compares completed accesses, hold stability and the post-access gap.
  always @(negedge clk) begin
    if (p_fin) chk("gap_after_access", bus_en, 0);
    if (bus_en && p_en && !p_fin) begin
      chk("hold_addr", bus_addr, p_addr);
      chk("hold_we", bus_we, p_we);
      chk("hold_data", bus_data_out, p_data);
    end
    if (bus_en && no_bus) chk("no_bus_traffic", bus_en, 0);
    if (bus_en && bus_ack && !bus_err) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access: addr %0h we %0b, none expected", bus_addr, bus_we);
      end else begin
        e_m = exp_q.pop_front();
        chk("acc_we", bus_we, e_m.we);
        chk("acc_addr", bus_addr, e_m.addr);
        if (e_m.we) chk("acc_data", bus_data_out, e_m.data);
      end
      acc_n++;
    end
    if (pkt_done) done_n++;
    p_en   = bus_en;
    p_fin  = bus_en && (bus_ack || bus_err);
    p_we   = bus_we;
    p_addr = bus_addr;
    p_data = bus_data_out;
  end
  task automatic flit(input logic [31:0] d, input logic last, input int maxw);
    int w = 0;
    @(negedge clk);
    in_valid = 1;
    in_flit  = d;
    in_last  = last;
    while (!in_ready && w < maxw) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    in_last  = 0;
  endtask
  task automatic wait_done(input int target, input int budget);
    int w = 0;
    while (done_n < target && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("pkt_done_count", done_n, target);
  endtask
  initial begin
    int w, a0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_data", bus_data_out, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_err", err, 0);
    rst = 0;
    push(0, STATUS, 0); push(1, DATA, 1); push(1, DATA, 32'hA5);
    flit(32'hA5, 1, 4);
    chk("ready_low_after_last", in_ready, 0);
    chk("busy_after_last", busy, 1);
    wait_done(1, 200);
    chk("t1_err", err, 0);
    chk("t1_queue_empty", exp_q.size(), 0);
    status_q = '{32'd2, 32'd5};
    push(0, STATUS, 0); push(0, STATUS, 0); push(1, DATA, 4);
    push(1, DATA, 32'h11); push(1, DATA, 32'h22); push(1, DATA, 32'h33); push(1, DATA, 32'h44);
    flit(32'h11, 0, 4); flit(32'h22, 0, 4); flit(32'h33, 0, 4); flit(32'h44, 1, 4);
    wait_done(2, 400);
    chk("t2_queue_empty", exp_q.size(), 0);
    no_bus = 1;
    for (int i = 0; i < SIZE + 3; i++) flit(32'h100 + i, 0, 0);
    flit(32'h1FF, 1, 0);
    repeat (3) @(negedge clk);
    chk("ovf_err", err, 1);
    chk("ovf_in_ready", in_ready, 1);
    chk("ovf_busy", busy, 0);
    chk("ovf_no_done", done_n, 2);
    no_bus = 0;
    wr_n = 0;
    err_at = 3;
    push(0, STATUS, 0); push(1, DATA, 3); push(1, DATA, 32'hB0);
    flit(32'hB0, 0, 4);
    chk("err_cleared_ovf", err, 0);
    flit(32'hB1, 0, 4); flit(32'hB2, 1, 4);
    w = 0;
    while (wr_n < 3 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("buserr_err", err, 1);
    chk("buserr_bus_en", bus_en, 0);
    chk("buserr_busy", busy, 0);
    chk("buserr_in_ready", in_ready, 1);
    chk("buserr_no_done", done_n, 2);
    chk("buserr_queue_empty", exp_q.size(), 0);
    err_at = -1;
    ack_delay = 5;
    stall = 1;
    push(0, STATUS, 0); push(1, DATA, 2); push(1, DATA, 32'hC0); push(1, DATA, 32'hC1);
    flit(32'hC0, 0, 4);
    chk("err_cleared_buserr", err, 0);
    flit(32'hC1, 1, 4);
    wait_done(3, 800);
    chk("t5_queue_empty", exp_q.size(), 0);
    ack_delay = 3;
    stall = 0;
    a0 = acc_n;
    push(0, STATUS, 0); push(1, DATA, 4); push(1, DATA, 32'hD0);
    flit(32'hD0, 0, 4); flit(32'hD1, 0, 4); flit(32'hD2, 0, 4); flit(32'hD3, 1, 4);
    w = 0;
    while (acc_n < a0 + 3 && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("wrflit_in_flight", bus_en, 1);
    rst = 1;
    @(negedge clk);
    chk("midrst_bus_en", bus_en, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    rst = 0;
    exp_q.delete();
    ack_delay = 0;
    push(0, STATUS, 0); push(1, DATA, 1); push(1, DATA, 32'h77);
    flit(32'h77, 1, 4);
    wait_done(4, 300);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
